// File: rtl/fetch_prefetch_buffer.sv
// Instruction fetch front end: credit-limited sequential fetch into a DEPTH-entry queue.
// Optional FETCH_PERF_EN adds perf_bubble_cnt / perf_drop_cnt saturating counters.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  input  logic        out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic [CW:0]   occupancy;
  logic [31:0]   new_pc;
  logic          issue, resp, push, pop, discard;

  always_comb begin
    occupancy = {1'b0, count} + {1'b0, outstanding};
    new_pc    = redirect_pc & ~32'd3;
    imem_req  = !reset && !redirect && (occupancy < DEPTH_W);
    imem_addr = fetch_pc;
    issue     = imem_req && imem_gnt;
    // Responses with nothing outstanding are protocol errors and ignored.
    resp      = imem_rvalid && (outstanding != '0);
    push      = resp && !redirect && (drop_cnt == '0);
    discard   = resp && (redirect || (drop_cnt != '0));
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    out_pc4   = out_valid ? (pc_mem[rd_ptr] + 32'd4) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= new_pc;
        resp_pc  <= new_pc;
        drop_cnt <= outstanding - CW'(resp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubble_cnt <= '0;
      perf_drop_cnt   <= '0;
    end else begin
      if (out_ready && !out_valid && !redirect && (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (discard && (perf_drop_cnt != '1))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && (count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Randomized bench for fetch_prefetch_buffer against a queue-based reference model
// and an in-order variable-latency instruction memory.
module tb_fetch_prefetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_drop_cnt;
`endif

  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc4(out_pc4), .out_ready(out_ready)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned due; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  req_t pend[$];
  ent_t mq[$];

  int unsigned n_vec = 0, n_err = 0, cyc = 0;
  int unsigned gnt_mode = 1, ready_mode = 1, lat_min = 1, lat_max = 1, hold_pct = 0;
  logic        primed = 1'b0;
  logic [31:0] m_fetch, m_resp;
  int          m_out, m_drop;
  logic [31:0] m_bub, m_pd;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic rd, input logic [31:0] rpc);
    logic m_req, hold;
    int   m_rsp, m_iss;
    @(negedge clk);
    cyc++;
    reset = rst; redirect = rd; redirect_pc = rpc;
    imem_gnt  = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : (gnt_mode != 0);
    out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode != 0);
    hold = ($urandom_range(0, 99) < hold_pct);
    if (rst) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end else if (!hold && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    m_req = !rst && !rd && ((mq.size() + m_out) < DEPTH);
    if (primed) begin
      check("imem_req", 32'(imem_req), 32'(m_req));
      check("imem_addr", imem_addr, m_fetch);
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("out_instr", out_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
      check("out_pc4", out_pc4, (mq.size() != 0) ? mq[0].pc + 32'd4 : 32'h0);
`ifdef FETCH_PERF_EN
      check("perf_bubble", perf_bubble_cnt, m_bub);
      check("perf_drop", perf_drop_cnt, m_pd);
`endif
    end
    if (!rst && imem_req && imem_gnt)
      pend.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_min, lat_max)});
    if (rst) begin
      mq.delete();
      m_fetch = RESET_PC; m_resp = RESET_PC;
      m_out = 0; m_drop = 0; m_bub = '0; m_pd = '0;
      primed = 1'b1;
    end else begin
      m_rsp = (imem_rvalid && m_out > 0) ? 1 : 0;
      m_iss = (m_req && imem_gnt) ? 1 : 0;
      if (out_ready && mq.size() == 0 && !rd) m_bub++;
      if (rd) begin
        if (m_rsp != 0) m_pd++;
        mq.delete();
        m_fetch = rpc & ~32'd3;
        m_resp  = m_fetch;
        m_out   = m_out - m_rsp;
        m_drop  = m_out;
      end else begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (m_rsp != 0) begin
          if (m_drop > 0) begin
            m_drop--;
            m_pd++;
          end else begin
            mq.push_back('{instr: imem_rdata, pc: m_resp});
            m_resp += 32'd4;
          end
        end
        if (m_iss != 0) m_fetch += 32'd4;
        m_out = m_out + m_iss - m_rsp;
      end
    end
  endtask

  task automatic wait_valid(input string tag, input int unsigned budget);
    logic seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      step(1'b0, 1'b0, '0);
      seen = out_valid;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int first_g, first_v, nvalid;
    logic seen;

    // Test 1: steady stream from reset, 1-cycle memory.
    gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1; hold_pct = 0;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    first_g = -1; first_v = -1;
    for (int unsigned i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0);
      if (first_g < 0 && imem_req && imem_gnt) first_g = int'(cyc);
      if (first_v < 0 && out_valid) first_v = int'(cyc);
    end
    check("t1_first_lat", 32'(first_v - first_g), 32'd2);

    // Test 2: consumer stall fills the queue to exactly DEPTH.
    ready_mode = 0;
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    check("t2_req_low", 32'(imem_req), 32'd0);
    gnt_mode = 0; ready_mode = 1; nvalid = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, '0);
      if (out_valid) nvalid++;
    end
    check("t2_held", 32'(nvalid), 32'd4);

    // Test 3: redirect with one queued entry and two responses in flight.
    step(1'b1, 1'b0, '0);
    gnt_mode = 1; ready_mode = 0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    hold_pct = 100;
    step(1'b0, 1'b0, '0);
    gnt_mode = 0;
    step(1'b0, 1'b1, 32'h0000_0043);
    hold_pct = 0; gnt_mode = 1; ready_mode = 1;
    wait_valid("t3_wait", 20);
    check("t3_pc4", out_pc4, 32'h44);
    check("t3_instr", out_instr, mem_word(32'h40));
`ifdef FETCH_PERF_EN
    check("t3_perf_drop", perf_drop_cnt, 32'd2);
`endif

    // Test 4: redirect coinciding with a response, then a second redirect.
    lat_min = 2; lat_max = 2;
    for (int unsigned i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b1, 32'h0000_0080);
    wait_valid("t4_wait", 20);
    check("t4_pc4", out_pc4, 32'h84);
    check("t4_instr", out_instr, mem_word(32'h80));

    // Test 5: random grant, latency, ready, response holds and redirects.
    gnt_mode = 2; ready_mode = 2; lat_min = 1; lat_max = 4; hold_pct = 10;
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) step(1'b0, 1'b1, $urandom);
      else step(1'b0, 1'b0, '0);
    end
    hold_pct = 0;

    // Test 6: reset mid-stream with three fetches outstanding.
    gnt_mode = 1; ready_mode = 1; lat_min = 4; lat_max = 4;
    seen = 1'b0;
    for (int unsigned i = 0; i < 30 && !seen; i++) begin
      step(1'b0, 1'b0, '0);
      seen = (m_out == 3);
    end
    check("t6_wait", 32'(seen), 32'd1);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, '0);
    check("t6_addr", imem_addr, RESET_PC);
    check("t6_req_on", 32'(imem_req), 32'd1);
    for (int unsigned i = 0; i < 20; i++) step(1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
